// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: shared widths, FSM encoding, direction constants, command record and forward phase table
package quad_enc_pkg;
  localparam int POS_W = 32;
  localparam int STEP_W = 16;
  localparam int DIV_W = 16;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  localparam logic [7:0] PHASE_FWD = {2'b01, 2'b11, 2'b10, 2'b00};
  typedef struct packed {
    logic dir;
    logic [DIV_W-1:0] period;
  } cmd_t;
  function automatic logic [1:0] phase_ab(input logic [1:0] idx);
    return PHASE_FWD[{idx, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/quad_enc_gen_if.sv
// quad_enc_gen_if: command handshake plus quadrature/status outputs; master = commander, slave = generator
interface quad_enc_gen_if import quad_enc_pkg::*; ;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic abort;
  logic a;
  logic b;
  logic busy;
  logic done;
  logic [POS_W-1:0] position;
  modport master(output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
                 input cmd_ready, a, b, busy, done, position);
  modport slave(input cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
                output cmd_ready, a, b, busy, done, position);
endinterface

// File: rtl/quad_rate_timer.sv
// quad_rate_timer: down-counter; clk, reset, load/val reload, en decrements, tick while count is zero
module quad_rate_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? val : en ? cnt_q - W'(1) : cnt_q;
    tick = cnt_q == '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/quad_enc_gen.sv
// quad_enc_gen: step commands to A/B quadrature; ports clk, reset (async), bus (slave: cmd handshake, abort, a/b, busy, done, position)
module quad_enc_gen import quad_enc_pkg::*; (
  input logic          clk,
  input logic          reset,
  quad_enc_gen_if.slave bus
);
  logic [0:0] st_q, st_d;
  cmd_t cmd_q, cmd_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0] ph_q, ph_d, ab_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic pend_q, done_q;
  logic run, hs, step, last, fin, tick;
  always_comb begin
    run = st_q == ST_RUN;
    hs = !run && bus.cmd_valid;
    // abort suppresses an edge that would fire in the same cycle
    step = run && tick && !bus.abort;
    last = step && rem_q == STEP_W'(1);
    fin = (hs && bus.cmd_steps == '0) || (run && bus.abort) || last;
    st_d = (hs && bus.cmd_steps != '0) ? ST_RUN : (run && (bus.abort || last)) ? ST_IDLE : st_q;
    cmd_d = hs ? cmd_t'{bus.cmd_dir, (bus.cmd_period == '0) ? DIV_W'(1) : bus.cmd_period} : cmd_q;
    rem_d = hs ? bus.cmd_steps : step ? rem_q - STEP_W'(1) : rem_q;
    ph_d = step ? (cmd_q.dir == DIR_FWD ? ph_q + 2'd1 : ph_q - 2'd1) : ph_q;
    pos_d = step ? (cmd_q.dir == DIR_FWD ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
  end
  // cmd_d holds the fresh period on handshake and the latched one otherwise
  quad_rate_timer #(.W(DIV_W)) u_timer (
    .clk(clk), .reset(reset), .load(hs || step), .en(run),
    .val(cmd_d.period - DIV_W'(1)), .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= ST_IDLE;
      cmd_q <= '0;
      rem_q <= '0;
      ph_q <= '0;
      ab_q <= '0;
      pos_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cmd_q <= cmd_d;
      rem_q <= rem_d;
      ph_q <= ph_d;
      ab_q <= phase_ab(ph_d);
      pos_q <= pos_d;
      // done trails the finishing event by one extra cycle
      pend_q <= fin;
      done_q <= pend_q;
    end
  assign bus.cmd_ready = st_q == ST_IDLE;
  assign bus.busy = st_q == ST_RUN;
  assign bus.a = ab_q[1];
  assign bus.b = ab_q[0];
  assign bus.done = done_q;
  assign bus.position = pos_q;
endmodule
